jpeg_capture_sequencer: RTL
===========================

# jpeg_capture_sequencer

Single-shot capture controller that sits between the host command/register block and the `jpeg_encoder` top level, on the pixel clock. It latches and validates the capture configuration, issues the encoder's start strobe only in a legal inter-frame gap, watches for completion and enforces a frame-count timeout. It also resets the encoder on abort or timeout and reports done/error status plus the final compressed image size.

## Interface
Parameters:
- `SENSOR_X_SIZE`, 1280, maximum accepted horizontal size.
- `SENSOR_Y_SIZE`, 720, maximum accepted vertical size.
- `TIMEOUT_FRAMES`, 3, number of frame_valid falling edges allowed in CAPTURE before timeout; must be ≥1.

Ports:
- `pixel_clock_in`  in  1  sole clock.
- `pixel_reset_n_in`  in  1  asynchronous, active-low reset.
- `capture_req_in`  in  1  single-cycle capture request.
- `abort_in`  in  1  single-cycle abort request.
- `compression_factor_in`  in  4  requested quality factor.
- `x_size_in`  in  $clog2(SENSOR_X_SIZE)  requested width.
- `y_size_in`  in  $clog2(SENSOR_Y_SIZE)  requested height.
- `frame_valid_in`  in  1  sensor frame valid.
- `image_valid_in`  in  1  encoder image-complete level.
- `address_in`  in  16  encoder byte address/size.
- `start_capture_out`  out  1  encoder start strobe.
- `encoder_reset_n_out`  out  1  synchronous active-low encoder reset, ANDed with the encoder's resets externally.
- `compression_factor_out`  out  4  shadowed config.
- `x_size_out`, `y_size_out`  out  as inputs  shadowed config.
- `busy_out`  out  1  capture in progress.
- `done_out`  out  1  last capture succeeded.
- `error_out`  out  2  0 none, 1 config, 2 timeout, 3 abort.
- `image_size_out`  out  16  compressed size in bytes.

## Operation
- States:
  - IDLE: after reset.
  - ARM: waiting for a legal inter-frame gap.
  - CAPTURE: encoder running.
  - FLUSH: encoder reset in progress.
  - DONE / ERROR: terminal status, held until the next request.
- **IDLE/DONE/ERROR**, on `capture_req_in`:
  - Shadow all three config inputs.
  - Clear `done_out`, `error_out` and `image_size_out`.
  - Validate the config: x and y must be nonzero, multiples of 16, and ≤ the sensor size.
  - Valid config → ARM. Invalid config → ERROR with code 1; the shadow registers are not updated.
- **ARM**: `start_capture_out = (state==ARM) & ~frame_valid_in`. This is combinational and asserts for exactly one cycle; the state moves to CAPTURE on that cycle. While `frame_valid_in` is high, stay in ARM.
- **CAPTURE**:
  - A 2-cycle guard counter masks `image_valid_in`, because a stale level from the previous image is still present until the encoder leaves its image-valid state.
  - After the guard, `image_valid_in` high → latch `address_in` into `image_size_out`, then go to DONE.
  - Each frame_valid falling edge (registered `fv_d & ~frame_valid_in`) increments the frame counter. When the counter reaches `TIMEOUT_FRAMES` → FLUSH with code 2.
- **abort_in** in ARM or CAPTURE → FLUSH with code 3. `abort_in` is ignored in all other states.
- **FLUSH**: drive `encoder_reset_n_out` low for 2 cycles, then go to ERROR with the pending code.
- **Request while busy**: `capture_req_in` in ARM, CAPTURE or FLUSH is dropped; no queueing.
- **Same-cycle priorities**:
  - Qualified `image_valid_in` and `abort_in` together → DONE (completion wins).
  - Qualified `image_valid_in` and the timeout edge together → DONE.
  - `capture_req_in` and `abort_in` together in IDLE → the request is accepted.
- `busy_out` is high in ARM, CAPTURE and FLUSH.

## Timing
- Reset values:
  - State IDLE.
  - `start_capture_out` 0, `encoder_reset_n_out` 1, `busy_out` 0, `done_out` 0, `error_out` 0, `image_size_out` 0.
  - `compression_factor_out` 0, `x_size_out` = SENSOR_X_SIZE, `y_size_out` = SENSOR_Y_SIZE.
  - Frame counter 0, guard counter 0, `fv_d` 0.
- All outputs are registered except `start_capture_out`.
- Latencies:
  - `capture_req_in` at cycle t → `busy_out` and the shadow registers update at t+1.
  - ARM at t+1 with `frame_valid_in` low → `start_capture_out` high at t+1.
  - Qualified `image_valid_in` at cycle c → `done_out` and `image_size_out` valid at c+1, `busy_out` low at c+1.
  - Abort at cycle a → `encoder_reset_n_out` low at a+1 and a+2, then `error_out` = 3 and `busy_out` low at a+3.
- Reset mid-capture returns every output to its reset value asynchronously. The encoder is cleared by the shared system reset.

## Structure
- `jpeg_ctrl_pkg`: state enum, error-code enum (`ERR_NONE`, `ERR_CFG`, `ERR_TIMEOUT`, `ERR_ABORT`), the guard length (2) and the flush length (2).
- Sub-module `frame_edge_counter`:
  - Registers `frame_valid_in`.
  - Counts falling edges, saturating at `TIMEOUT_FRAMES`.
  - Has a synchronous clear, driven on entry to CAPTURE.
  - Flags `expired`.

## Test plan
- **Nominal capture**: request with 1280×720, factor 2, while `frame_valid_in` is low → `start_capture_out` for 1 cycle, state CAPTURE. Then `image_valid_in` with `address_in` = 0x3A40 → `done_out` = 1, `image_size_out` = 0x3A40, `busy_out` = 0.
- **Start deferred to gap**: request while `frame_valid_in` is high → no strobe until `frame_valid_in` falls, then the strobe appears on that same cycle.
- **Config errors**: x = 1000 (not a multiple of 16) → `error_out` = 1 at t+1, no strobe. x = 0 → same. y = 736 → same.
- **Timeout**: `TIMEOUT_FRAMES` = 3, three frame_valid pulses with no `image_valid_in` → `encoder_reset_n_out` low for 2 cycles, then `error_out` = 2.
- **Stale image_valid and same-cycle priority**:
  - Hold `image_valid_in` high across the strobe and drop it 2 cycles later → no false DONE.
  - `abort_in` on the same cycle as a qualified `image_valid_in` → DONE, `error_out` = 0.
- **Busy and reset behaviour**:
  - A second request during CAPTURE is ignored; the shadow registers are unchanged.
  - Reset asserted mid-CAPTURE → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and timing constants for the JPEG capture sequencer.
package jpeg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_CAPTURE, ST_FLUSH, ST_DONE, ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_CFG = 2'd1, ERR_TIMEOUT = 2'd2, ERR_ABORT = 2'd3
  } err_e;

  localparam int GUARD_LEN = 2;
  localparam int FLUSH_LEN = 2;

endpackage

// File: rtl/jpeg_capture_sequencer_frame_edge_counter.sv
// Counts frame_valid falling edges while enabled; saturates at TIMEOUT_FRAMES.
module frame_edge_counter #(
  parameter int TIMEOUT_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_valid_in,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);

  logic          fv_q, fv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall;

  assign fall = fv_q & ~frame_valid_in;

  always_comb begin
    fv_d  = frame_valid_in;
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && fall && cnt_q != CW'(TIMEOUT_FRAMES))
      cnt_d = cnt_q + 1'b1;
  end

  // Flag on the edge that reaches the limit so the FSM reacts without a cycle of lag.
  assign expired = (cnt_q == CW'(TIMEOUT_FRAMES)) |
                   (en & fall & (cnt_q == CW'(TIMEOUT_FRAMES - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      fv_q  <= fv_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jpeg_capture_sequencer.sv
// Single-shot capture controller: validates config, starts the encoder in a
// frame gap, watches for completion/timeout/abort and reports status.
module jpeg_capture_sequencer
  import jpeg_ctrl_pkg::*;
#(
  parameter int SENSOR_X_SIZE  = 1280,
  parameter int SENSOR_Y_SIZE  = 720,
  parameter int TIMEOUT_FRAMES = 3
) (
  input  logic                             pixel_clock_in,
  input  logic                             pixel_reset_n_in,
  input  logic                             capture_req_in,
  input  logic                             abort_in,
  input  logic [3:0]                       compression_factor_in,
  input  logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_in,
  input  logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_in,
  input  logic                             frame_valid_in,
  input  logic                             image_valid_in,
  input  logic [15:0]                      address_in,
  output logic                             start_capture_out,
  output logic                             encoder_reset_n_out,
  output logic [3:0]                       compression_factor_out,
  output logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_out,
  output logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_out,
  output logic                             busy_out,
  output logic                             done_out,
  output logic [1:0]                       error_out,
  output logic [15:0]                      image_size_out
);
  localparam int XW = $clog2(SENSOR_X_SIZE);
  localparam int YW = $clog2(SENSOR_Y_SIZE);

  state_e          state_q, state_d;
  err_e            pend_q, pend_d, err_q, err_d;
  logic [1:0]      guard_q, guard_d, flush_q, flush_d;
  logic [3:0]      cf_q, cf_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [15:0]     size_q, size_d;
  logic            busy_q, busy_d, done_q, done_d, enc_rst_n_q, enc_rst_n_d;
  logic            cfg_ok, iv_qual, expired, fec_en, fec_clr;

  frame_edge_counter #(.TIMEOUT_FRAMES(TIMEOUT_FRAMES)) u_fec (
    .clk            (pixel_clock_in),
    .rst_n          (pixel_reset_n_in),
    .frame_valid_in (frame_valid_in),
    .en             (fec_en),
    .clr            (fec_clr),
    .expired        (expired)
  );

  assign cfg_ok = (x_size_in != '0) && (x_size_in[3:0] == 4'd0) && (int'(x_size_in) <= SENSOR_X_SIZE) &&
                  (y_size_in != '0) && (y_size_in[3:0] == 4'd0) && (int'(y_size_in) <= SENSOR_Y_SIZE);
  // The encoder's image_valid level from the previous image lingers for a couple of cycles.
  assign iv_qual = (state_q == ST_CAPTURE) && (guard_q == 2'(GUARD_LEN)) && image_valid_in;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    err_d   = err_q;
    guard_d = guard_q;
    flush_d = flush_q;
    cf_d    = cf_q;
    x_d     = x_q;
    y_d     = y_q;
    size_d  = size_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (capture_req_in) begin
        done_d = 1'b0;
        err_d  = ERR_NONE;
        size_d = '0;
        if (cfg_ok) begin
          cf_d    = compression_factor_in;
          x_d     = x_size_in;
          y_d     = y_size_in;
          state_d = ST_ARM;
        end else begin
          err_d   = ERR_CFG;
          state_d = ST_ERROR;
        end
      end
      ST_ARM: begin
        if (abort_in) begin
          pend_d  = ERR_ABORT;
          flush_d = '0;
          state_d = ST_FLUSH;
        end else if (!frame_valid_in) begin
          guard_d = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (guard_q != 2'(GUARD_LEN)) guard_d = guard_q + 2'd1;
        if (iv_qual) begin
          done_d  = 1'b1;
          size_d  = address_in;
          state_d = ST_DONE;
        end else if (abort_in || expired) begin
          pend_d  = abort_in ? ERR_ABORT : ERR_TIMEOUT;
          flush_d = '0;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_q == 2'(FLUSH_LEN - 1)) begin
          err_d   = pend_q;
          state_d = ST_ERROR;
        end else begin
          flush_d = flush_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    start_capture_out = (state_q == ST_ARM) & ~frame_valid_in;
    fec_clr           = start_capture_out;
    fec_en            = (state_q == ST_CAPTURE);
    busy_d            = (state_d == ST_ARM) || (state_d == ST_CAPTURE) || (state_d == ST_FLUSH);
    enc_rst_n_d       = (state_d != ST_FLUSH);
  end

  always_ff @(posedge pixel_clock_in or negedge pixel_reset_n_in) begin
    if (!pixel_reset_n_in) begin
      state_q     <= ST_IDLE;
      pend_q      <= ERR_NONE;
      err_q       <= ERR_NONE;
      guard_q     <= '0;
      flush_q     <= '0;
      cf_q        <= '0;
      x_q         <= XW'(SENSOR_X_SIZE);
      y_q         <= YW'(SENSOR_Y_SIZE);
      size_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enc_rst_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      guard_q     <= guard_d;
      flush_q     <= flush_d;
      cf_q        <= cf_d;
      x_q         <= x_d;
      y_q         <= y_d;
      size_q      <= size_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      enc_rst_n_q <= enc_rst_n_d;
    end
  end

  assign encoder_reset_n_out    = enc_rst_n_q;
  assign compression_factor_out = cf_q;
  assign x_size_out             = x_q;
  assign y_size_out             = y_q;
  assign busy_out               = busy_q;
  assign done_out               = done_q;
  assign error_out              = err_q;
  assign image_size_out         = size_q;

endmodule
